axi_sram_slave: RTL and testbench
=================================

# axi_sram_slave

AXI3-style single-port SRAM responder, the subordinate end of the memory interface that core_top drives through axi_bridge. It serves instruction-fetch and data traffic: one read burst and one write burst in flight concurrently, with INCR, FIXED and WRAP bursts of 32-bit beats. It sits below core_top in the simulation SoC and in the FPGA wrapper.

## Interface
- MEM_WORDS, 65536, depth in 32-bit words; power of two.
- BASE_ADDR, 32'h1c00_0000, byte address of word 0; aligned to MEM_WORDS*4.
- clk input 1: clock, all logic on rising edge.
- reset input 1: synchronous, active-high.
- arid input 4: read ID.
- araddr input 32: read start byte address.
- arlen input 8: beats minus 1.
- arburst input 2: 00 FIXED, 01 INCR, 10 WRAP.
- arvalid input 1: AR valid.
- arready output 1: AR ready.
- rid output 4: echoes the accepted arid.
- rdata output 32: read beat data.
- rresp output 2: 00 OKAY, 10 SLVERR, 11 DECERR.
- rlast output 1: final beat.
- rvalid output 1: R valid.
- rready input 1: R ready.
- awid input 4: write ID.
- awaddr input 32: write start byte address.
- awlen input 8: beats minus 1.
- awburst input 2: encoding as arburst.
- awvalid input 1: AW valid.
- awready output 1: AW ready.
- wdata input 32: write beat data.
- wstrb input 4: byte enables.
- wlast input 1: final beat flag from the master.
- wvalid input 1: W valid.
- wready output 1: W ready.
- bid output 4: echoes the accepted awid.
- bresp output 2: write response.
- bvalid output 1: B valid.
- bready input 1: B ready.

The master-side signals arsize, awsize, wid, lock, cache and prot are not ports. The top ties them off, and every beat is 4 bytes.

## Operation
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1; an AR handshake latches id, address, len and burst, then moves to R_DATA.
  - R_DATA: arready=0; stays until the beat with rlast=1 handshakes, then returns to R_IDLE.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1; AW handshake -> W_DATA.
  - W_DATA: wready=1; each beat with wvalid&wready writes the strobed bytes. The beat where count==awlen -> W_RESP.
  - W_RESP: bvalid=1 until bready.
- Beat address, working on word index = addr[31:2]:
  - FIXED: the index never changes.
  - INCR: index+1 per beat, wrapping modulo 2^30.
  - WRAP: only the low log2(len+1) index bits increment, so the burst wraps inside an aligned (len+1)-word block.
- Address errors:
  - A beat outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*4) gets DECERR.
  - Such a read beat returns rdata=0; such a write beat is dropped.
  - bresp reports the worst response across all beats of the burst.
- Burst-shape errors:
  - WRAP with len not in {1,3,7,15}, or burst type 11, gives SLVERR on every beat.
  - Memory is still accessed as INCR.
  - A wlast value that disagrees with count==awlen gives bresp SLVERR; the burst still ends at count==awlen.

## Timing
- All outputs reset to 0 except arready=1 and awready=1; both FSMs reset to IDLE and memory contents are not reset.
- Read latency: AR handshake in cycle T gives the first rvalid in T+1. With rready held high, beats follow back-to-back and a len-N burst completes in T+N+1.
- Read hold rule: rdata, rresp and rlast are registered and stay stable while rvalid&!rready.
- Read-before-write: the next beat's data is captured in the handshake cycle, so a write to the same word in that cycle is not seen.
- Write timing: AW in T gives wready in T+1; last W in T+k gives bvalid in T+k+1; awready returns the cycle after the B handshake.
- Reset asserted mid-burst aborts both FSMs and drops any partial write response.

## Configuration
- AXI_SLAVE_RAND_STALL_EN defined: a 16-bit LFSR (seed 16'hACE1) gates arready, awready and wready low on random cycles, and can insert idle cycles before any rvalid. Ordering, data and responses are unchanged.
- Undefined: no stalls, and the timing above is exact.

## Structure
- axi_pkg holds the burst and response encodings (AXI_BURST_FIXED/INCR/WRAP, AXI_RESP_OKAY/SLVERR/DECERR), AXI_ID_WD=4 and the next-address function.
- One sub-module, axi_burst_addr (start index, len, burst -> next index plus the SLVERR flag), is instantiated twice.

## Test plan
- INCR read, araddr 1c00_0010, arlen 3, preloaded words 0..7 = i -> rdata 4,5,6,7; rlast only on 7; rvalid one cycle after AR.
- WRAP write, awaddr 1c00_0038, awlen 3, wstrb F -> words 14,15,12,13 written; bresp 00; bvalid one cycle after the last W.
- Write with wstrb 4'b0101, wdata AABBCCDD over 0 -> word = 00BB00DD.
- araddr 0000_0000, arlen 1 -> two beats of rdata 0 with rresp 11; awburst 11 -> bresp 10.
- Concurrent read and write bursts to disjoint words, rready toggling every cycle -> no beat lost or duplicated; reset mid-read gives rvalid 0 and arready 1 the next cycle.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the SRAM responder: burst and response
// encodings, ID width, FSM state types and the beat-address helpers.
package axi_pkg;

  localparam int AXI_ID_WD = 4;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic {R_IDLE, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

  // Reserved burst type, or WRAP with a length that is not 2/4/8/16 beats.
  function automatic logic axi_shape_err(input logic [7:0] len, input logic [1:0] burst);
    return (burst == 2'b11) ||
           ((burst == AXI_BURST_WRAP) &&
            !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)));
  endfunction

  // Word index of the beat following idx; malformed bursts walk as INCR.
  function automatic logic [29:0] axi_next_index(input logic [29:0] idx,
                                                 input logic [7:0]  len,
                                                 input logic [1:0]  burst);
    logic [29:0] mask;
    mask = {22'd0, len};
    if (burst == AXI_BURST_FIXED)
      return idx;
    if ((burst == AXI_BURST_WRAP) && !axi_shape_err(len, burst))
      return (idx & ~mask) | ((idx + 30'd1) & mask);
    return idx + 30'd1;
  endfunction

  // Responses are ordered OKAY < SLVERR < DECERR, so the numerically larger one is worse.
  function automatic logic [1:0] axi_worst_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3-style read/write channel bundle between a master and the SRAM responder.
interface axi_sram_slave_if;
  import axi_pkg::*;

  logic [AXI_ID_WD-1:0] arid;
  logic [31:0]          araddr;
  logic [7:0]           arlen;
  logic [1:0]           arburst;
  logic                 arvalid;
  logic                 arready;

  logic [AXI_ID_WD-1:0] rid;
  logic [31:0]          rdata;
  logic [1:0]           rresp;
  logic                 rlast;
  logic                 rvalid;
  logic                 rready;

  logic [AXI_ID_WD-1:0] awid;
  logic [31:0]          awaddr;
  logic [7:0]           awlen;
  logic [1:0]           awburst;
  logic                 awvalid;
  logic                 awready;

  logic [31:0]          wdata;
  logic [3:0]           wstrb;
  logic                 wlast;
  logic                 wvalid;
  logic                 wready;

  logic [AXI_ID_WD-1:0] bid;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;

  modport master (
    output arid, araddr, arlen, arburst, arvalid, rready,
    output awid, awaddr, awlen, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  arid, araddr, arlen, arburst, arvalid, rready,
    input  awid, awaddr, awlen, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid,
    output awready, wready, bid, bresp, bvalid
  );

endinterface

// File: rtl/axi_burst_addr.sv
// Beat address stepper: given the current word index and burst shape,
// produces the next word index and flags a malformed burst shape.
module axi_burst_addr
  import axi_pkg::*;
(
  input  logic [29:0] idx_i,
  input  logic [7:0]  len_i,
  input  logic [1:0]  burst_i,
  output logic [29:0] nextIdx_o,
  output logic        shapeErr_o
);

  assign nextIdx_o  = axi_next_index(idx_i, len_i, burst_i);
  assign shapeErr_o = axi_shape_err(len_i, burst_i);

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3-style single-port SRAM responder with one read and one write burst
// in flight. Optional feature: define AXI_SLAVE_RAND_STALL_EN to stall the
// ready signals on pseudo-random cycles from a 16-bit LFSR.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int          MEM_WORDS = 65536,
  parameter logic [31:0] BASE_ADDR = 32'h1c00_0000
) (
  input  logic             clk,
  input  logic             reset,
  axi_sram_slave_if.slave  axi
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] mem [MEM_WORDS];

  // Word index falls inside the aligned window starting at BASE_ADDR.
  function automatic logic inRange(input logic [29:0] idx);
    return idx[29:AW] == BASE_ADDR[31:AW+2];
  endfunction

  logic stall;

`ifdef AXI_SLAVE_RAND_STALL_EN
  logic [15:0] lfsr_q;

  // Free-running Fibonacci LFSR; its low bit decides which cycles stall.
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // ---------------- read side ----------------
  rd_state_e            rState_q;
  logic                 arready_q, rvalid_q, rlast_q;
  logic [31:0]          rdata_q;
  logic [1:0]           rresp_q;
  logic [AXI_ID_WD-1:0] rid_q;
  logic [29:0]          rIdx_q;
  logic [7:0]           rLen_q, rCount_q;
  logic [1:0]           rBurst_q;

  logic [29:0] rSelIdx, rNextIdx;
  logic [7:0]  rSelLen;
  logic [1:0]  rSelBurst, rBeatResp;
  logic        rShapeErr, rInRange, arFire, rFire;
  logic [31:0] rBeatData;

  assign axi.arready = arready_q & ~stall;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign axi.rlast   = rlast_q;
  assign axi.rid     = rid_q;

  assign arFire = axi.arvalid & axi.arready;
  assign rFire  = rvalid_q & axi.rready;

  // While idle the stepper looks at the incoming AR, otherwise at the next beat to fetch.
  assign rSelIdx   = (rState_q == R_IDLE) ? axi.araddr[31:2] : rIdx_q;
  assign rSelLen   = (rState_q == R_IDLE) ? axi.arlen        : rLen_q;
  assign rSelBurst = (rState_q == R_IDLE) ? axi.arburst      : rBurst_q;

  axi_burst_addr uRdAddr (
    .idx_i      (rSelIdx),
    .len_i      (rSelLen),
    .burst_i    (rSelBurst),
    .nextIdx_o  (rNextIdx),
    .shapeErr_o (rShapeErr)
  );

  assign rInRange  = inRange(rSelIdx);
  assign rBeatData = rInRange ? mem[rSelIdx[AW-1:0]] : 32'd0;
  assign rBeatResp = !rInRange ? AXI_RESP_DECERR :
                     rShapeErr ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

  // Read FSM: each beat is fetched into the output registers when the previous one handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rState_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= AXI_RESP_OKAY;
      rid_q     <= '0;
      rIdx_q    <= 30'd0;
      rLen_q    <= 8'd0;
      rCount_q  <= 8'd0;
      rBurst_q  <= AXI_BURST_FIXED;
    end else begin
      case (rState_q)
        R_IDLE: begin
          if (arFire) begin
            rid_q     <= axi.arid;
            rLen_q    <= axi.arlen;
            rBurst_q  <= axi.arburst;
            rIdx_q    <= rNextIdx;
            rCount_q  <= 8'd0;
            rdata_q   <= rBeatData;
            rresp_q   <= rBeatResp;
            rlast_q   <= (axi.arlen == 8'd0);
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rState_q  <= R_DATA;
          end
        end
        R_DATA: begin
          if (rFire) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              rState_q  <= R_IDLE;
            end else begin
              rdata_q  <= rBeatData;
              rresp_q  <= rBeatResp;
              rIdx_q   <= rNextIdx;
              rCount_q <= rCount_q + 8'd1;
              rlast_q  <= ((rCount_q + 8'd1) == rLen_q);
            end
          end
        end
        default: rState_q <= R_IDLE;
      endcase
    end
  end

  // ---------------- write side ----------------
  wr_state_e            wState_q;
  logic                 awready_q, wready_q, bvalid_q;
  logic [1:0]           bresp_q, wRespAcc_q;
  logic [AXI_ID_WD-1:0] bid_q;
  logic [29:0]          wIdx_q;
  logic [7:0]           wLen_q, wCount_q;
  logic [1:0]           wBurst_q;

  logic [29:0] wSelIdx, wNextIdx;
  logic [7:0]  wSelLen;
  logic [1:0]  wSelBurst, wBeatResp, wAccum;
  logic        wShapeErr, wInRange, wLastErr, awFire, wFire, bFire, memWe;

  assign axi.awready = awready_q & ~stall;
  assign axi.wready  = wready_q & ~stall;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.bid     = bid_q;

  assign awFire = axi.awvalid & axi.awready;
  assign wFire  = axi.wvalid & axi.wready;
  assign bFire  = bvalid_q & axi.bready;

  assign wSelIdx   = (wState_q == W_IDLE) ? axi.awaddr[31:2] : wIdx_q;
  assign wSelLen   = (wState_q == W_IDLE) ? axi.awlen        : wLen_q;
  assign wSelBurst = (wState_q == W_IDLE) ? axi.awburst      : wBurst_q;

  axi_burst_addr uWrAddr (
    .idx_i      (wSelIdx),
    .len_i      (wSelLen),
    .burst_i    (wSelBurst),
    .nextIdx_o  (wNextIdx),
    .shapeErr_o (wShapeErr)
  );

  assign wInRange  = inRange(wSelIdx);
  assign wLastErr  = axi.wlast != (wCount_q == wLen_q);
  assign wBeatResp = !wInRange ? AXI_RESP_DECERR :
                     wShapeErr ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign wAccum    = axi_worst_resp(axi_worst_resp(wRespAcc_q, wBeatResp),
                                    wLastErr ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
  assign memWe     = (wState_q == W_DATA) && wFire && wInRange && !reset;

  // Write FSM: accumulate the worst beat response and end the burst on the count, not on wlast.
  always_ff @(posedge clk) begin
    if (reset) begin
      wState_q   <= W_IDLE;
      awready_q  <= 1'b1;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= AXI_RESP_OKAY;
      bid_q      <= '0;
      wIdx_q     <= 30'd0;
      wLen_q     <= 8'd0;
      wCount_q   <= 8'd0;
      wBurst_q   <= AXI_BURST_FIXED;
      wRespAcc_q <= AXI_RESP_OKAY;
    end else begin
      case (wState_q)
        W_IDLE: begin
          if (awFire) begin
            bid_q      <= axi.awid;
            wLen_q     <= axi.awlen;
            wBurst_q   <= axi.awburst;
            wIdx_q     <= axi.awaddr[31:2];
            wCount_q   <= 8'd0;
            wRespAcc_q <= AXI_RESP_OKAY;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            wState_q   <= W_DATA;
          end
        end
        W_DATA: begin
          if (wFire) begin
            wRespAcc_q <= wAccum;
            wIdx_q     <= wNextIdx;
            wCount_q   <= wCount_q + 8'd1;
            if (wCount_q == wLen_q) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= wAccum;
              wState_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bFire) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wState_q  <= W_IDLE;
          end
        end
        default: wState_q <= W_IDLE;
      endcase
    end
  end

  // Byte-masked SRAM write port; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int b = 0; b < 4; b++) begin
        if (axi.wstrb[b]) mem[wSelIdx[AW-1:0]][b*8 +: 8] <= axi.wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: bursts of each type, strobes, address
// and shape errors, concurrent traffic with a throttled R channel, and reset.
module tb_axi_sram_slave;
  import axi_pkg::*;

  logic clk = 1'b0;
  logic reset;

  axi_sram_slave_if axi();

  axi_sram_slave dut (
    .clk   (clk),
    .reset (reset),
    .axi   (axi)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] rdData [16];
  logic [1:0]  rdResp [16];
  logic        rdLast [16];
  int          rdCount;
  int          rdCycles;
  logic [31:0] wrData [16];
  logic [1:0]  wrResp;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive every master-side signal to its idle value.
  task automatic applyStimulus();
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arburst = '0; axi.arvalid = 1'b0;
    axi.rready = 1'b0;
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awburst = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
    axi.bready = 1'b0;
  endtask

  // One write burst using wrData; checks handshake timing and captures bresp.
  task automatic writeBurst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] strb, input bit badLast, input string tag);
    int n;
    @(negedge clk);
    axi.awaddr = addr; axi.awlen = len; axi.awburst = burst; axi.awid = 4'h5; axi.awvalid = 1'b1;
    n = 0;
    while (axi.awready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checkOutput({tag, "_awready_wait"}, n, 0);
    @(negedge clk);
    axi.awvalid = 1'b0;
    checkOutput({tag, "_wready_lat"}, axi.wready, 1);
    for (int i = 0; i <= int'(len); i++) begin
      axi.wdata  = wrData[i];
      axi.wstrb  = strb;
      axi.wlast  = badLast ? (i == 0) : (i == int'(len));
      axi.wvalid = 1'b1;
      n = 0;
      while (axi.wready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      checkOutput({tag, "_wready_wait"}, n, 0);
      @(negedge clk);
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    checkOutput({tag, "_bvalid_lat"}, axi.bvalid, 1);
    checkOutput({tag, "_bid"}, axi.bid, 5);
    wrResp = axi.bresp;
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    checkOutput({tag, "_bvalid_clr"}, axi.bvalid, 0);
    checkOutput({tag, "_awready_back"}, axi.awready, 1);
  endtask

  // One read burst into rdData/rdResp/rdLast; toggle throttles rready every other cycle.
  task automatic readBurst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input bit toggle, input string tag);
    int n;
    bit done;
    bit phase;
    @(negedge clk);
    axi.araddr = addr; axi.arlen = len; axi.arburst = burst; axi.arid = 4'h9; axi.arvalid = 1'b1;
    n = 0;
    while (axi.arready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checkOutput({tag, "_arready_wait"}, n, 0);
    @(negedge clk);
    axi.arvalid = 1'b0;
    checkOutput({tag, "_rvalid_lat"}, axi.rvalid, 1);
    rdCount = 0; rdCycles = 0; done = 1'b0; phase = 1'b1;
    while (!done && rdCycles < 200) begin
      axi.rready = toggle ? phase : 1'b1;
      if (axi.rvalid && axi.rready) begin
        checkOutput({tag, "_rid"}, axi.rid, 9);
        if (rdCount < 16) begin
          rdData[rdCount] = axi.rdata;
          rdResp[rdCount] = axi.rresp;
          rdLast[rdCount] = axi.rlast;
        end
        if (axi.rlast || rdCount >= 15) done = 1'b1;
        rdCount++;
      end
      phase = ~phase;
      @(negedge clk);
      rdCycles++;
    end
    axi.rready = 1'b0;
    checkOutput({tag, "_beats"}, rdCount, int'(len) + 1);
    checkOutput({tag, "_rvalid_clr"}, axi.rvalid, 0);
    checkOutput({tag, "_arready_back"}, axi.arready, 1);
  endtask

  initial begin
    applyStimulus();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    checkOutput("rst_arready", axi.arready, 1);
    checkOutput("rst_awready", axi.awready, 1);
    checkOutput("rst_rvalid",  axi.rvalid,  0);
    checkOutput("rst_wready",  axi.wready,  0);
    checkOutput("rst_bvalid",  axi.bvalid,  0);

    // Preload words 0..7 with their index through an INCR write
    for (int i = 0; i < 8; i++) wrData[i] = i;
    writeBurst(32'h1c00_0000, 8'd7, AXI_BURST_INCR, 4'hF, 1'b0, "preload");
    checkOutput("preload_bresp", wrResp, AXI_RESP_OKAY);

    // INCR read of words 4..7, rready held high
    readBurst(32'h1c00_0010, 8'd3, AXI_BURST_INCR, 1'b0, "incr_rd");
    checkOutput("incr_rd_cycles", rdCycles, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("incr_rd_data%0d", i), rdData[i], 32'd4 + i);
      checkOutput($sformatf("incr_rd_last%0d", i), rdLast[i], (i == 3));
      checkOutput($sformatf("incr_rd_resp%0d", i), rdResp[i], AXI_RESP_OKAY);
    end

    // WRAP write from word 14: fills 14,15,12,13
    for (int i = 0; i < 4; i++) wrData[i] = 32'hA0 + i;
    writeBurst(32'h1c00_0038, 8'd3, AXI_BURST_WRAP, 4'hF, 1'b0, "wrap_wr");
    checkOutput("wrap_wr_bresp", wrResp, AXI_RESP_OKAY);
    readBurst(32'h1c00_0030, 8'd3, AXI_BURST_INCR, 1'b0, "wrap_chk");
    checkOutput("wrap_w12", rdData[0], 32'hA2);
    checkOutput("wrap_w13", rdData[1], 32'hA3);
    checkOutput("wrap_w14", rdData[2], 32'hA0);
    checkOutput("wrap_w15", rdData[3], 32'hA1);

    // Byte strobes over a zeroed word
    wrData[0] = 32'h0;
    writeBurst(32'h1c00_0080, 8'd0, AXI_BURST_INCR, 4'hF, 1'b0, "strb_clr");
    wrData[0] = 32'hAABB_CCDD;
    writeBurst(32'h1c00_0080, 8'd0, AXI_BURST_INCR, 4'b0101, 1'b0, "strb_wr");
    readBurst(32'h1c00_0080, 8'd0, AXI_BURST_FIXED, 1'b0, "strb_rd");
    checkOutput("strb_data", rdData[0], 32'h00BB_00DD);

    // Read outside the window: DECERR with zero data
    readBurst(32'h0000_0000, 8'd1, AXI_BURST_INCR, 1'b0, "dec_rd");
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("dec_rd_data%0d", i), rdData[i], 32'd0);
      checkOutput($sformatf("dec_rd_resp%0d", i), rdResp[i], AXI_RESP_DECERR);
    end
    checkOutput("dec_rd_last1", rdLast[1], 1);

    // Reserved burst type on a write: SLVERR
    wrData[0] = 32'h1111_1111; wrData[1] = 32'h2222_2222;
    writeBurst(32'h1c00_0100, 8'd1, 2'b11, 4'hF, 1'b0, "rsv_wr");
    checkOutput("rsv_wr_bresp", wrResp, AXI_RESP_SLVERR);

    // wlast on the wrong beats: SLVERR, burst still ends on the count
    wrData[0] = 32'h3333_3333; wrData[1] = 32'h4444_4444;
    writeBurst(32'h1c00_0110, 8'd1, AXI_BURST_INCR, 4'hF, 1'b1, "wlast_wr");
    checkOutput("wlast_wr_bresp", wrResp, AXI_RESP_SLVERR);

    // Top word of the window, then one past the end
    wrData[0] = 32'h1234_5678;
    writeBurst(32'h1c03_fffc, 8'd0, AXI_BURST_INCR, 4'hF, 1'b0, "top_wr");
    checkOutput("top_wr_bresp", wrResp, AXI_RESP_OKAY);
    writeBurst(32'h1c04_0000, 8'd0, AXI_BURST_INCR, 4'hF, 1'b0, "past_wr");
    checkOutput("past_wr_bresp", wrResp, AXI_RESP_DECERR);
    readBurst(32'h1c03_fffc, 8'd1, AXI_BURST_INCR, 1'b0, "edge_rd");
    checkOutput("edge_rd_data0", rdData[0], 32'h1234_5678);
    checkOutput("edge_rd_resp0", rdResp[0], AXI_RESP_OKAY);
    checkOutput("edge_rd_data1", rdData[1], 32'd0);
    checkOutput("edge_rd_resp1", rdResp[1], AXI_RESP_DECERR);

    // WRAP with an illegal length: SLVERR per beat, memory walked as INCR
    readBurst(32'h1c00_0000, 8'd2, AXI_BURST_WRAP, 1'b0, "badwrap_rd");
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("badwrap_data%0d", i), rdData[i], i);
      checkOutput($sformatf("badwrap_resp%0d", i), rdResp[i], AXI_RESP_SLVERR);
    end

    // Concurrent read (throttled R) and write to disjoint words
    for (int i = 0; i < 4; i++) wrData[i] = 32'hC0DE_0000 + i;
    fork
      writeBurst(32'h1c00_00a0, 8'd3, AXI_BURST_INCR, 4'hF, 1'b0, "conc_wr");
      readBurst(32'h1c00_0000, 8'd7, AXI_BURST_INCR, 1'b1, "conc_rd");
    join
    checkOutput("conc_wr_bresp", wrResp, AXI_RESP_OKAY);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("conc_rd_data%0d", i), rdData[i], i);
      checkOutput($sformatf("conc_rd_last%0d", i), rdLast[i], (i == 7));
    end
    readBurst(32'h1c00_00a0, 8'd3, AXI_BURST_INCR, 1'b0, "conc_chk");
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("conc_chk_data%0d", i), rdData[i], 32'hC0DE_0000 + i);

    // Reset in the middle of a read burst
    @(negedge clk);
    axi.araddr = 32'h1c00_0000; axi.arlen = 8'd7; axi.arburst = AXI_BURST_INCR; axi.arvalid = 1'b1;
    @(negedge clk);
    axi.arvalid = 1'b0; axi.rready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_rvalid", axi.rvalid, 0);
    checkOutput("midrst_arready", axi.arready, 1);
    reset = 1'b0; axi.rready = 1'b0;
    readBurst(32'h1c00_0008, 8'd0, AXI_BURST_INCR, 1'b0, "post_rst");
    checkOutput("post_rst_data", rdData[0], 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
